// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets, STATUS bit layout,
// store size codes and the transmit FSM encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // A divisor of zero would never end a bit, so it is stored as one.
  function automatic logic [15:0] div_fix(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; simultaneous push and pop are legal, also when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr, r_rptr;
  logic             w_do_push, w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  assign o_full    = (o_count == FULL_CNT);
  assign o_empty   = (o_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + CW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter, shifter and FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_hit,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   r_state, w_state_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [15:0] r_bit_div, w_bit_div_nxt;
  logic [15:0] r_baud_div, w_baud_new;
  logic        r_tx, w_tx_nxt;
  logic        r_overflow;
  logic [31:0] r_read_data, w_rd_word;
  logic        r_read_hit;

  logic          w_wr_hit, w_rd_hit, w_push, w_pop, w_bit_end;
  logic          w_full, w_empty;
  logic [7:0]    w_fifo_data;
  logic [CW-1:0] w_count;
  logic          w_unused;

  assign w_wr_hit  = write_mem && (write_address[31:4] == BASE_ADDR[31:4]);
  assign w_rd_hit  = (read_address[31:4] == BASE_ADDR[31:4]);
  assign w_push    = w_wr_hit && (write_address[3:2] == OFF_TXDATA);
  assign w_bit_end = (r_baud_cnt == r_bit_div - 16'd1);
  assign w_unused  = ^{write_address[1:0], read_address[1:0], write_data[31:16]};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (write_data[7:0]),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_div_nxt  = r_bit_div;
    w_pop          = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_nxt    = w_fifo_data;
          w_bit_div_nxt  = r_baud_div;
          w_baud_cnt_nxt = '0;
          w_state_nxt    = StStart;
        end
      end
      StStart: begin
        w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_state_nxt    = StData;
        end
      end
      StData: begin
        w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end
      end
      StStop: begin
        w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_fifo_data;
            w_bit_div_nxt = r_baud_div;
            w_state_nxt   = StStart;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    case (w_state_nxt)
      StStart: w_tx_nxt = 1'b0;
      StData:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_baud_new = (funct3 == F3_SB) ? {r_baud_div[15:8], write_data[7:0]} : write_data[15:0];
    w_rd_word  = '0;
    if (w_rd_hit) begin
      case (read_address[3:2])
        OFF_STATUS: begin
          w_rd_word[ST_FULL]               = w_full;
          w_rd_word[ST_EMPTY]              = w_empty;
          w_rd_word[ST_BUSY]               = (r_state != StIdle);
          w_rd_word[ST_OVF]                = r_overflow;
          w_rd_word[ST_CNT_LSB+3:ST_CNT_LSB] = 4'(w_count);
        end
        OFF_BAUD: w_rd_word[15:0] = r_baud_div;
        default:  w_rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_baud_cnt  <= '0;
      r_bit_div   <= DEFAULT_DIV;
      r_tx        <= 1'b1;
      r_baud_div  <= DEFAULT_DIV;
      r_overflow  <= 1'b0;
      r_read_data <= '0;
      r_read_hit  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_baud_cnt  <= w_baud_cnt_nxt;
      r_bit_div   <= w_bit_div_nxt;
      r_tx        <= w_tx_nxt;
      r_read_data <= w_rd_word;
      r_read_hit  <= w_rd_hit;
      if (w_wr_hit && (write_address[3:2] == OFF_BAUD)) r_baud_div <= div_fix(w_baud_new);
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else if (w_wr_hit && (write_address[3:2] == OFF_STATUS) && write_data[ST_OVF]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign read_data = r_read_data;
  assign read_hit  = r_read_hit;
  assign tx        = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, serial-line decoder with a byte scoreboard,
// and hand-written sequences for latency, overflow and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst, write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address, write_data, read_address, read_data;
  logic        read_hit, tx;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb[$];
  bit         mon_en  = 1'b0;
  int         mon_div = 4;

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[12];

  mmio_uart_tx dut (
    .clk           (clk),
    .rst           (rst),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_hit      (read_hit),
    .tx            (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    write_mem     = 1'b1;
    funct3        = f3;
    write_address = a;
    write_data    = d;
    tick();
    write_mem     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    read_address = a;
    tick();
    d            = read_data;
    h            = read_hit;
    read_address = '0;
  endtask

  task automatic push(input logic [7:0] b, input bit expect_sent);
    if (expect_sent) sb.push_back(b);
    wr(3'b010, BASE, {24'h0, b});
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] s;
    logic        h;
    int          n;
    n = 0;
    do begin
      rd(BASE + 32'h4, s, h);
      n++;
    end while ((s[2] || sb.size() != 0) && n < limit);
    check("drain_busy", {31'b0, s[2]}, 32'h0);
    check("drain_queue", sb.size(), 32'h0);
  endtask

  // Serial decoder: first sample lands half a cycle into the start bit, then one per bit period.
  always begin
    @(negedge clk);
    if (mon_en && tx === 1'b0) begin
      int         d;
      logic [7:0] b;
      d = mon_div;
      for (int i = 0; i < 8; i++) begin
        repeat (d) @(negedge clk);
        b[i] = tx;
      end
      repeat (d) @(negedge clk);
      check("stop_bit", {31'b0, tx}, 32'h1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_unexpected: got 0x%0h expected no frame", b);
      end else begin
        check("frame_data", {24'h0, b}, {24'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        h;
    logic [9:0]  fr;
    int          lows;

    vecs[0]  = '{1'b1, 3'b010, BASE + 32'h8,  32'h0000_1234, BASE + 32'h8,  32'h1234, 1'b1};
    vecs[1]  = '{1'b1, 3'b000, BASE + 32'h8,  32'hFFFF_FFAB, BASE + 32'h8,  32'h12AB, 1'b1};
    vecs[2]  = '{1'b1, 3'b001, BASE + 32'h8,  32'h5678_9ABC, BASE + 32'h8,  32'h9ABC, 1'b1};
    vecs[3]  = '{1'b1, 3'b010, BASE + 32'h8,  32'h0000_0000, BASE + 32'h8,  32'h0001, 1'b1};
    vecs[4]  = '{1'b1, 3'b000, BASE + 32'h8,  32'h0000_0000, BASE + 32'h8,  32'h0001, 1'b1};
    vecs[5]  = '{1'b1, 3'b010, BASE + 32'hC,  32'hFFFF_FFFF, BASE + 32'hC,  32'h0,    1'b1};
    vecs[6]  = '{1'b0, 3'b010, 32'h0,         32'h0,         BASE,          32'h0,    1'b1};
    vecs[7]  = '{1'b0, 3'b010, 32'h0,         32'h0,         BASE - 32'h4,  32'h0,    1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h0,         32'h0,         BASE + 32'h10, 32'h0,    1'b0};
    vecs[9]  = '{1'b1, 3'b010, BASE + 32'h18, 32'h0000_7777, BASE + 32'h8,  32'h0001, 1'b1};
    vecs[10] = '{1'b1, 3'b010, BASE + 32'h8,  32'h0000_0004, BASE + 32'h8,  32'h0004, 1'b1};
    vecs[11] = '{1'b0, 3'b010, 32'h0,         32'h0,         BASE + 32'h4,  32'h0002, 1'b1};

    rst           = 1'b1;
    write_mem     = 1'b0;
    funct3        = 3'b010;
    write_address = '0;
    write_data    = '0;
    read_address  = '0;
    repeat (3) tick();
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_read_data", read_data, 32'h0);
    check("rst_read_hit", {31'b0, read_hit}, 32'h0);
    rst = 1'b0;
    rd(BASE + 32'h4, d, h);
    check("rst_status", d, 32'h02);
    check("rst_status_hit", {31'b0, h}, 32'h1);
    rd(BASE + 32'h8, d, h);
    check("rst_baud", d, 32'h68);

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].f3, vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d, h);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_hit", i), {31'b0, h}, {31'b0, vecs[i].exp_hit});
    end

    // Exact waveform of one frame at divisor 4, including the two-edge start latency.
    fr = {1'b1, 8'h55, 1'b0};
    wr(3'b010, BASE, 32'h55);
    check("wave_e1", {31'b0, tx}, 32'h1);
    for (int k = 2; k <= 42; k++) begin
      tick();
      if (k <= 41) check($sformatf("wave_e%0d", k), {31'b0, tx}, {31'b0, fr[(k-2)/4]});
      else         check("wave_idle", {31'b0, tx}, 32'h1);
    end

    // Nine bytes: one in flight plus a full FIFO, no overflow.
    mon_en  = 1'b1;
    mon_div = 4;
    for (int i = 0; i < 9; i++) push(8'(i), 1'b1);
    rd(BASE + 32'h4, d, h);
    check("nine_status_full", d, 32'h85);
    wait_idle(600);

    // Divisor change mid-frame applies from the next frame only.
    push(8'hA5, 1'b1);
    repeat (10) tick();
    wr(3'b010, BASE + 32'h8, 32'h6);
    mon_div = 6;
    push(8'h3C, 1'b1);
    wait_idle(400);
    rd(BASE + 32'h8, d, h);
    check("div_change_baud", d, 32'h6);
    mon_en = 1'b0;

    // Overflow with the line stalled on a huge divisor.
    wr(3'b010, BASE + 32'h8, 32'hFFFF);
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i), 1'b0);
    rd(BASE + 32'h4, d, h);
    check("ovf_status", d, 32'h8D);
    wr(3'b010, BASE + 32'h4, 32'h7);
    rd(BASE + 32'h4, d, h);
    check("ovf_kept", d, 32'h8D);
    wr(3'b010, BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4, d, h);
    check("ovf_cleared", d, 32'h85);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_rst_tx", {31'b0, tx}, 32'h1);
    rd(BASE + 32'h4, d, h);
    check("ovf_rst_status", d, 32'h02);

    // Reset in the middle of data bit 3 aborts the frame and flushes the FIFO.
    wr(3'b010, BASE + 32'h8, 32'h4);
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    repeat (17) tick();
    check("bit3_low", {31'b0, tx}, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tx", {31'b0, tx}, 32'h1);
    rd(BASE + 32'h4, d, h);
    check("midrst_status", d, 32'h02);
    rd(BASE + 32'h8, d, h);
    check("midrst_baud", d, 32'h68);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("midrst_quiet", lows, 32'h0);

    check("sb_leftover", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
